// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: owns the PC, reads 1- or 2-byte instructions
// from ROM and presents the decoded fields to the controller until they are acknowledged.
module instr_fetch_unit #(
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned DATA_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = 8'h00
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_en,
  input  logic              pc_load,
  input  logic [ADDR_W-1:0] pc_load_addr,
  input  logic [DATA_W-1:0] rom_data,
  input  logic              rom_ready,
  output logic              rom_ena,
  output logic              rom_read,
  output logic [ADDR_W-1:0] addr,
  output logic [ADDR_W-1:0] pc_ad,
  output logic [3:0]        ins,
  output logic [3:0]        reg_ad,
  output logic [7:0]        ir_ad,
  output logic              ir_valid,
  input  logic              ir_ack,
  output logic [1:0]        fetch
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    F1   = 2'b01,
    F2   = 2'b10,
    HOLD = 2'b11
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [3:0]        ins_q, ins_d;
  logic [3:0]        reg_ad_q, reg_ad_d;
  logic [7:0]        ir_ad_q, ir_ad_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      pc_q     <= RESET_PC;
      ins_q    <= '0;
      reg_ad_q <= '0;
      ir_ad_q  <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ins_q    <= ins_d;
      reg_ad_q <= reg_ad_d;
      ir_ad_q  <= ir_ad_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ins_d    = ins_q;
    reg_ad_d = reg_ad_q;
    ir_ad_d  = ir_ad_q;

    // Redirect wins over everything, including ROM data and ir_ack this cycle.
    if (pc_load) begin
      pc_d    = pc_load_addr;
      state_d = fetch_en ? F1 : IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (fetch_en) state_d = F1;
        end
        F1: begin
          if (rom_ready) begin
            ins_d    = rom_data[7:4];
            reg_ad_d = rom_data[3:0];
            pc_d     = pc_q + 1'b1;
            if (rom_data[7]) begin
              state_d = F2;
            end else begin
              ir_ad_d = '0;
              state_d = HOLD;
            end
          end
        end
        F2: begin
          if (rom_ready) begin
            ir_ad_d = rom_data[7:0];
            pc_d    = pc_q + 1'b1;
            state_d = HOLD;
          end
        end
        HOLD: begin
          if (ir_ack) state_d = fetch_en ? F1 : IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign rom_read = (state_q == F1) || (state_q == F2);
  assign rom_ena  = rom_read;
  assign ir_valid = (state_q == HOLD);
  assign addr     = pc_q;
  assign pc_ad    = pc_q;
  assign ins      = ins_q;
  assign reg_ad   = reg_ad_q;
  assign ir_ad    = ir_ad_q;
  assign fetch    = state_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: a byte-array ROM answers addr combinationally.
`timescale 1ns/1ps
module tb_instr_fetch_unit;

  logic       clk;
  logic       rst;
  logic       fetch_en;
  logic       pc_load;
  logic [7:0] pc_load_addr;
  logic [7:0] rom_data;
  logic       rom_ready;
  logic       rom_ena;
  logic       rom_read;
  logic [7:0] addr;
  logic [7:0] pc_ad;
  logic [3:0] ins;
  logic [3:0] reg_ad;
  logic [7:0] ir_ad;
  logic       ir_valid;
  logic       ir_ack;
  logic [1:0] fetch;

  logic [7:0] rom [256];
  int unsigned n_cmp;
  int unsigned n_bad;

  instr_fetch_unit #(.ADDR_W(8), .DATA_W(8), .RESET_PC(8'h00)) dut (
    .clk(clk), .rst(rst), .fetch_en(fetch_en), .pc_load(pc_load),
    .pc_load_addr(pc_load_addr), .rom_data(rom_data), .rom_ready(rom_ready),
    .rom_ena(rom_ena), .rom_read(rom_read), .addr(addr), .pc_ad(pc_ad),
    .ins(ins), .reg_ad(reg_ad), .ir_ad(ir_ad), .ir_valid(ir_valid),
    .ir_ack(ir_ack), .fetch(fetch)
  );

  assign rom_data = rom[addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_hold(input string tag, input logic [3:0] e_ins, input logic [3:0] e_reg,
                            input logic [7:0] e_ir, input logic [7:0] e_pc);
    check({tag, ".fetch"},  32'(fetch),    32'h3);
    check({tag, ".valid"},  32'(ir_valid), 32'h1);
    check({tag, ".rdoff"},  32'(rom_read), 32'h0);
    check({tag, ".ins"},    32'(ins),      32'(e_ins));
    check({tag, ".reg_ad"}, 32'(reg_ad),   32'(e_reg));
    check({tag, ".ir_ad"},  32'(ir_ad),    32'(e_ir));
    check({tag, ".pc_ad"},  32'(pc_ad),    32'(e_pc));
  endtask

  task automatic check_reset(input string tag);
    check({tag, ".fetch"},  32'(fetch),    32'h0);
    check({tag, ".rdoff"},  32'(rom_read), 32'h0);
    check({tag, ".enaoff"}, 32'(rom_ena),  32'h0);
    check({tag, ".valid"},  32'(ir_valid), 32'h0);
    check({tag, ".addr"},   32'(addr),     32'h0);
    check({tag, ".pc_ad"},  32'(pc_ad),    32'h0);
    check({tag, ".ins"},    32'(ins),      32'h0);
    check({tag, ".reg_ad"}, 32'(reg_ad),   32'h0);
    check({tag, ".ir_ad"},  32'(ir_ad),    32'h0);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    for (int i = 0; i < 256; i++) rom[i] = 8'h00;
    rom[8'h00] = 8'h25;
    rst = 1'b0; fetch_en = 1'b0; pc_load = 1'b0; pc_load_addr = 8'h00;
    rom_ready = 1'b0; ir_ack = 1'b0;

    // reset then 1-byte fetch
    #0.05;
    check_reset("rst0");
    #0.05;
    rst = 1'b1; fetch_en = 1'b1; rom_ready = 1'b1;
    tick();
    check("t1.f1", 32'(fetch), 32'h1);
    check("t1.rd", 32'(rom_read), 32'h1);
    check("t1.ena", 32'(rom_ena), 32'h1);
    check("t1.addr", 32'(addr), 32'h00);
    tick();
    check_hold("t1", 4'h2, 4'h5, 8'h00, 8'h01);
    tick();
    check_hold("t1.stay", 4'h2, 4'h5, 8'h00, 8'h01);

    // two-byte fetch, ack one cycle after valid
    rst = 1'b0; #1;
    check_reset("rst1");
    rom[8'h00] = 8'hA3; rom[8'h01] = 8'h7C;
    rst = 1'b1;
    tick();
    check("t2.f1", 32'(fetch), 32'h1);
    tick();
    check("t2.f2", 32'(fetch), 32'h2);
    check("t2.f2addr", 32'(addr), 32'h01);
    check("t2.f2valid", 32'(ir_valid), 32'h0);
    tick();
    check_hold("t2", 4'hA, 4'h3, 8'h7C, 8'h02);
    tick();
    check_hold("t2.stay", 4'hA, 4'h3, 8'h7C, 8'h02);
    ir_ack = 1'b1;
    tick();
    ir_ack = 1'b0;
    check("t2.next", 32'(fetch), 32'h1);
    check("t2.naddr", 32'(addr), 32'h02);

    // wait states: rom_ready low for three edges in F1
    rst = 1'b0; #1;
    rom[8'h00] = 8'h25;
    rom_ready = 1'b0;
    rst = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      check("t3.wf1", 32'(fetch), 32'h1);
      check("t3.waddr", 32'(addr), 32'h00);
      check("t3.wrd", 32'(rom_read), 32'h1);
      check("t3.wpc", 32'(pc_ad), 32'h00);
      if (i < 3) tick();
    end
    rom_ready = 1'b1;
    tick();
    check_hold("t3", 4'h2, 4'h5, 8'h00, 8'h01);

    // redirect during F2
    rst = 1'b0; #1;
    rom[8'h00] = 8'hA3; rom[8'h40] = 8'h25;
    rst = 1'b1;
    tick();
    tick();
    check("t4.f2", 32'(fetch), 32'h2);
    pc_load = 1'b1; pc_load_addr = 8'h40;
    tick();
    pc_load = 1'b0;
    check("t4.f1", 32'(fetch), 32'h1);
    check("t4.valid", 32'(ir_valid), 32'h0);
    check("t4.addr", 32'(addr), 32'h40);
    check("t4.pc", 32'(pc_ad), 32'h40);
    tick();
    check_hold("t4", 4'h2, 4'h5, 8'h00, 8'h41);

    // redirect plus ack in the same HOLD cycle
    rom[8'h10] = 8'h31;
    pc_load = 1'b1; pc_load_addr = 8'h10; ir_ack = 1'b1;
    tick();
    pc_load = 1'b0; ir_ack = 1'b0;
    check("t5.f1", 32'(fetch), 32'h1);
    check("t5.addr", 32'(addr), 32'h10);
    check("t5.valid", 32'(ir_valid), 32'h0);
    tick();
    check_hold("t5", 4'h3, 4'h1, 8'h00, 8'h11);

    // 2-byte opcode at FF wraps to 00 for its operand
    rom[8'hFF] = 8'hC7; rom[8'h00] = 8'h5E;
    pc_load = 1'b1; pc_load_addr = 8'hFF; ir_ack = 1'b1;
    tick();
    pc_load = 1'b0; ir_ack = 1'b0;
    check("t6.addrff", 32'(addr), 32'hFF);
    tick();
    check("t6.f2", 32'(fetch), 32'h2);
    check("t6.addr00", 32'(addr), 32'h00);
    tick();
    check_hold("t6", 4'hC, 4'h7, 8'h5E, 8'h01);

    // back-to-back 1-byte fetches with ir_ack tied high (ignored in F1)
    rom[8'h01] = 8'h25; rom[8'h02] = 8'h31; rom[8'h03] = 8'h00;
    ir_ack = 1'b1;
    tick();
    check("t7.f1a", 32'(fetch), 32'h1);
    check("t7.addr1", 32'(addr), 32'h01);
    tick();
    check_hold("t7a", 4'h2, 4'h5, 8'h00, 8'h02);
    tick();
    check("t7.f1b", 32'(fetch), 32'h1);
    tick();
    check_hold("t7b", 4'h3, 4'h1, 8'h00, 8'h03);
    tick();
    check("t7.f1c", 32'(fetch), 32'h1);

    // fetch_en low in F1: current instruction still completes, then IDLE
    fetch_en = 1'b0;
    tick();
    check_hold("t8", 4'h0, 4'h0, 8'h00, 8'h04);
    tick();
    ir_ack = 1'b0;
    check("t8.idle", 32'(fetch), 32'h0);
    check("t8.enaoff", 32'(rom_ena), 32'h0);
    check("t8.valid", 32'(ir_valid), 32'h0);
    tick();
    check("t8.stayidle", 32'(fetch), 32'h0);

    // reset asserted mid-F1 acts before any clock edge
    fetch_en = 1'b1;
    tick();
    check("t9.f1", 32'(fetch), 32'h1);
    check("t9.rd", 32'(rom_read), 32'h1);
    rst = 1'b0;
    #1;
    check_reset("t9");
    rst = 1'b1;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
Front-end stage of the 8-bit RISC core. It owns the program counter and fetches 1- or 2-byte instructions from instruction ROM over a ready handshake. It assembles opcode, register address and address operand, then presents them to the core's decode/controller FSM with a valid/ack handshake. Jumps and calls redirect it through pc_load.

Parameters:
ADDR_W, 8, program-counter and ROM address width
DATA_W, 8, ROM data width; must be 8
RESET_PC, 8'h00, PC value after reset

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-low reset
fetch_en  in  1  allows leaving IDLE and starting a new fetch
pc_load  in  1  redirect request (jump/acall/return)
pc_load_addr  in  ADDR_W  redirect target
rom_data  in  DATA_W  ROM read data
rom_ready  in  1  ROM data valid this cycle
rom_ena  out  1  ROM chip enable
rom_read  out  1  ROM read strobe
addr  out  ADDR_W  ROM address
pc_ad  out  ADDR_W  current PC
ins  out  4  opcode, byte0[7:4]
reg_ad  out  4  register address, byte0[3:0]
ir_ad  out  8  address operand, byte1; 8'h00 for 1-byte instructions
ir_valid  out  1  instruction fields valid
ir_ack  in  1  controller consumes the instruction
fetch  out  2  state code: 00 IDLE, 01 F1, 10 F2, 11 HOLD

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, pc=RESET_PC.
  - ins, reg_ad, ir_ad all 0.
  - ir_valid, rom_ena and rom_read all 0.
  - addr=RESET_PC.
  - Reset mid-fetch aborts immediately; rom_read drops in the same cycle, with no clock edge needed.
- Instruction length: ins[3]=1 means 2-byte (byte1 = ir_ad); ins[3]=0 means 1-byte.
- IDLE:
  - rom_ena=rom_read=0, ir_valid=0.
  - When fetch_en=1, go to F1 on the next edge.
- F1:
  - rom_ena=rom_read=1, addr=pc.
  - On an edge with rom_ready=1: latch ins/reg_ad from rom_data and set pc<=pc+1.
  - If ins[3]=1, go to F2. Otherwise clear ir_ad to 0 and go to HOLD.
  - With rom_ready=0, hold F1 indefinitely with addr stable.
- F2:
  - rom_ena=rom_read=1, addr=pc.
  - On an edge with rom_ready=1: latch ir_ad, set pc<=pc+1, go to HOLD.
- HOLD:
  - ir_valid=1, rom_read=0.
  - ins/reg_ad/ir_ad stay stable until accepted.
  - On an edge with ir_ack=1, go to F1 if fetch_en=1, else IDLE.
  - ir_ack is ignored outside HOLD.
- Latency (rom_ready tied 1, starting at F1 entry):
  - 1-byte instruction: ir_valid rises 1 cycle later.
  - 2-byte instruction: ir_valid rises 2 cycles later.
  - Back-to-back throughput with ir_ack tied 1: one 1-byte instruction every 2 cycles.
- PC arithmetic: modulo 2^ADDR_W, so 8'hFF+1 = 8'h00. A 2-byte instruction at 8'hFF takes its operand from 8'h00.
- pc_load (highest priority, any non-reset state):
  - Next edge: pc<=pc_load_addr, ir_valid drops, any partial fetch is discarded.
  - Next state is F1 if fetch_en=1, else IDLE.
  - rom_data arriving in that same cycle is dropped.
- pc_load and ir_ack in the same cycle: the held instruction counts as consumed and the redirect is taken; no refetch at the old PC.
- fetch_en=0 during F1/F2: the current instruction completes to HOLD; only the next fetch is blocked.
- pc_ad always equals the internal pc.
- rom_ena equals rom_read; both are registered-state decodes (Moore, no dependence on rom_ready).

Test Plan:
- Reset then fetch: rst low 100 ps, release with fetch_en=1, rom_ready=1, ROM[00]=8'h25 -> fetch 01 then 11; ins=2, reg_ad=5, ir_ad=00, ir_valid=1, pc_ad=01.
- Two-byte fetch: ROM[00]=8'hA3, ROM[01]=8'h7C, ir_ack one cycle after valid -> states 01,10,11; ins=A, reg_ad=3, ir_ad=7C, pc_ad=02; next addr=02.
- Wait states: rom_ready low for 3 cycles in F1 -> addr=00 and rom_read=1 held for 4 cycles; no pc change until the ready edge; the result matches the zero-wait case.
- Redirect: pc_load=1, pc_load_addr=8'h40 during F2 -> partial instruction discarded, ir_valid stays 0, next addr=40, pc_ad=40.
- Redirect plus ack: pc_load (addr 8'h10) and ir_ack in the same HOLD cycle -> next state F1 with addr=10; old instruction not re-presented.
- Wrap and mid-op reset:
  - 2-byte opcode at 8'hFF -> operand read at 8'h00, pc_ad=01.
  - Reset asserted during F1 -> rom_read=0 and pc=00 immediately, before the next edge.
